fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word fetches to instruction memory, buffers
// returned instructions in order and presents them one at a time to decode.
// A redirect from execute flushes the queue and discards stale responses.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] boot_addr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus_4
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_W = DEPTH[CW:0];
    localparam logic [CW-1:0]   ONE     = 1;
    localparam logic [PW-1:0]   PTR_ONE = 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

    logic [CW:0]   inflight;
    logic [CW-1:0] out_next;
    logic [31:0]   redirect_word;
    logic          grant;
    logic          push;
    logic          pop;

    // Request/decode handshakes and the outstanding-beat bookkeeping.
    always_comb begin
        inflight      = {1'b0, count} + {1'b0, outstanding};
        imem_req      = rst_n && !redirect && (inflight < DEPTH_W);
        imem_addr     = fetch_pc;
        grant         = imem_req && imem_gnt;
        push          = imem_rvalid && !redirect && (drop == '0);
        id_valid      = (count != '0) && !redirect;
        pop           = id_valid && id_ready;
        id_instr      = id_valid ? q_instr[head] : NOP_INSTR;
        id_pc         = q_pc[head];
        id_pc_plus_4  = id_pc + 32'd4;
        redirect_word = redirect_pc & ~32'd3;
        out_next      = outstanding;
        if (grant)       out_next = out_next + ONE;
        if (imem_rvalid) out_next = out_next - ONE;
    end

    // Fetch pointers, occupancy and queue storage; redirect overrides push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= boot_addr;
            resp_pc     <= boot_addr;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            head        <= '0;
            tail        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= NOP_INSTR;
                q_pc[i]    <= '0;
            end
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                // Every beat still owed by memory after this cycle is stale.
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                fetch_pc <= redirect_word;
                resp_pc  <= redirect_word;
                drop     <= out_next;
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rvalid && drop != '0) drop <= drop - ONE;
                if (push) begin
                    q_instr[tail] <= imem_rdata;
                    q_pc[tail]    <= resp_pc;
                    tail          <= tail + PTR_ONE;
                    resp_pc       <= resp_pc + 32'd4;
                end
                if (pop) head <= head + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + ONE;
                    2'b01:   count <= count - ONE;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
